// File: rtl/id_ex_forward_reg.sv
// ID/EX pipeline register with registered operand-forwarding selects and load-use stall detection.
// Selects are resolved in ID against the EX and MEM producers so EX sees them straight from flops.
module id_ex_forward_reg #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned REG_AW     = 4,
    parameter bit          ZERO_REG   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  hold,
    input  logic                  id_valid,
    input  logic [REG_AW-1:0]     id_rs_addr,
    input  logic [REG_AW-1:0]     id_rt_addr,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [DATA_WIDTH-1:0] id_rs_data,
    input  logic [DATA_WIDTH-1:0] id_rt_data,
    input  logic [REG_AW-1:0]     id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [REG_AW-1:0]     mem_rd_addr,
    input  logic                  mem_reg_write,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ex_rs_data,
    output logic [DATA_WIDTH-1:0] ex_rt_data,
    output logic [REG_AW-1:0]     ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall
);

    localparam logic [1:0] SelRf    = 2'd0;
    localparam logic [1:0] SelExMem = 2'd1;
    localparam logic [1:0] SelMemWb = 2'd2;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] rs_data_q, rs_data_d;
    logic [DATA_WIDTH-1:0] rt_data_q, rt_data_d;
    logic [REG_AW-1:0]     rd_addr_q, rd_addr_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_read_q, mem_read_d;
    logic [1:0]            sel_a_q, sel_a_d;
    logic [1:0]            sel_b_q, sel_b_d;

    logic       rs_zero, rt_zero;
    logic       hazard_rs, hazard_rt;
    logic       ex_writes;
    logic [1:0] sel_a_calc, sel_b_calc;

    // Index 0 is never a real producer/consumer link when hard-wired to zero.
    assign rs_zero = ZERO_REG && (id_rs_addr == '0);
    assign rt_zero = ZERO_REG && (id_rt_addr == '0);

    assign hazard_rs = id_uses_rs && !rs_zero && (id_rs_addr == rd_addr_q);
    assign hazard_rt = id_uses_rt && !rt_zero && (id_rt_addr == rd_addr_q);

    assign stall = id_valid && valid_q && mem_read_q && reg_write_q && (hazard_rs || hazard_rt);

    assign ex_writes = valid_q && reg_write_q;

    always_comb begin
        sel_a_calc = SelRf;
        if (id_uses_rs && !rs_zero) begin
            if (ex_writes && (rd_addr_q == id_rs_addr)) begin
                sel_a_calc = SelExMem;
            end else if (mem_reg_write && (mem_rd_addr == id_rs_addr)) begin
                sel_a_calc = SelMemWb;
            end
        end
    end

    always_comb begin
        sel_b_calc = SelRf;
        if (id_uses_rt && !rt_zero) begin
            if (ex_writes && (rd_addr_q == id_rt_addr)) begin
                sel_b_calc = SelExMem;
            end else if (mem_reg_write && (mem_rd_addr == id_rt_addr)) begin
                sel_b_calc = SelMemWb;
            end
        end
    end

    always_comb begin
        valid_d     = valid_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        rd_addr_d   = rd_addr_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        if (flush || (!hold && stall)) begin
            valid_d     = 1'b0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            rd_addr_d   = '0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            sel_a_d     = SelRf;
            sel_b_d     = SelRf;
        end else if (!hold) begin
            valid_d     = id_valid;
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            rd_addr_d   = id_rd_addr;
            reg_write_d = id_valid && id_reg_write;
            mem_read_d  = id_valid && id_mem_read;
            sel_a_d     = id_valid ? sel_a_calc : SelRf;
            sel_b_d     = id_valid ? sel_b_calc : SelRf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            sel_a_q     <= SelRf;
            sel_b_q     <= SelRf;
        end else begin
            valid_q     <= valid_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rs_data   = rs_data_q;
    assign ex_rt_data   = rt_data_q;
    assign ex_rd_addr   = rd_addr_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign fwd_sel_a    = sel_a_q;
    assign fwd_sel_b    = sel_b_q;

endmodule

// File: tb/tb_id_ex_forward_reg.sv
// Bench for id_ex_forward_reg: per-scenario tasks push expected EX state into a queue
// as stimulus is driven and pop/compare it after the capturing edge.
module tb_id_ex_forward_reg;

    typedef struct packed {
        logic        v;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [3:0]  rd;
        logic        rw;
        logic        mr;
        logic [1:0]  sa;
        logic [1:0]  sb;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        hold;
    logic        id_valid;
    logic [3:0]  id_rs_addr;
    logic [3:0]  id_rt_addr;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [15:0] id_rs_data;
    logic [15:0] id_rt_data;
    logic [3:0]  id_rd_addr;
    logic        id_reg_write;
    logic        id_mem_read;
    logic [3:0]  mem_rd_addr;
    logic        mem_reg_write;
    logic        ex_valid;
    logic [15:0] ex_rs_data;
    logic [15:0] ex_rt_data;
    logic [3:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic        stall;

    int   checks = 0;
    int   passes = 0;
    ex_t  sb_q[$];
    ex_t  exp_e;
    ex_t  got_e;

    always #5 clk = ~clk;

    id_ex_forward_reg #(
        .DATA_WIDTH(16),
        .REG_AW    (4),
        .ZERO_REG  (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .hold         (hold),
        .id_valid     (id_valid),
        .id_rs_addr   (id_rs_addr),
        .id_rt_addr   (id_rt_addr),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_rd_addr   (id_rd_addr),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .mem_rd_addr  (mem_rd_addr),
        .mem_reg_write(mem_reg_write),
        .ex_valid     (ex_valid),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .ex_rd_addr   (ex_rd_addr),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall        (stall)
    );

    function automatic ex_t observed();
        observed = '{v: ex_valid, rs: ex_rs_data, rt: ex_rt_data, rd: ex_rd_addr,
                     rw: ex_reg_write, mr: ex_mem_read, sa: fwd_sel_a, sb: fwd_sel_b};
    endfunction

    function automatic ex_t mk(input logic v, input logic [15:0] rs, input logic [15:0] rt,
                               input logic [3:0] rd, input logic rw, input logic mr,
                               input logic [1:0] sa, input logic [1:0] sb);
        mk = '{v: v, rs: rs, rt: rt, rd: rd, rw: rw, mr: mr, sa: sa, sb: sb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                            input logic urs, input logic urt, input logic [15:0] rsd,
                            input logic [15:0] rtd, input logic [3:0] rd, input logic rw,
                            input logic mr);
        id_valid     = v;
        id_rs_addr   = rs;
        id_rt_addr   = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_rs_data   = rsd;
        id_rt_data   = rtd;
        id_rd_addr   = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        hold = 1'b0;
        mem_rd_addr = 4'd0;
        mem_reg_write = 1'b0;
        drive_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        sb_q.push_back(mk(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0));
        #3;
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e || stall !== 1'b0) $display("FAIL reset_initial: got %h stall %b, expected %h stall 0", got_e, stall, exp_e);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        // EX gets a load to r5, then ID reads r5 to create a stall
        drive_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 16'h1111, 16'h2222, 4'd5, 1'b1, 1'b1);
        sb_q.push_back(mk(1'b1, 16'h1111, 16'h2222, 4'd5, 1'b1, 1'b1, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL load_r5: got %h, expected %h", got_e, exp_e);
        else passes++;
        drive_id(1'b1, 4'd5, 4'd6, 1'b1, 1'b0, 16'h3333, 16'h4444, 4'd7, 1'b1, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b1) $display("FAIL pre_reset_stall: got %b, expected 1", stall);
        else passes++;
        rst = 1'b1;
        sb_q.push_back(mk(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0));
        #1;
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e || stall !== 1'b0) $display("FAIL reset_mid_stall: got %h stall %b, expected %h stall 0", got_e, stall, exp_e);
        else passes++;
        sb_q.push_back(mk(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL reset_held_edge: got %h, expected %h", got_e, exp_e);
        else passes++;
        rst = 1'b0;
        drive_id(1'b1, 4'd6, 4'd7, 1'b1, 1'b1, 16'hAAAA, 16'h5555, 4'd8, 1'b1, 1'b0);
        sb_q.push_back(mk(1'b1, 16'hAAAA, 16'h5555, 4'd8, 1'b1, 1'b0, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL post_reset_load: got %h, expected %h", got_e, exp_e);
        else passes++;
    endtask

    task automatic test_fwd_ex();
        drive_id(1'b1, 4'd9, 4'd10, 1'b1, 1'b1, 16'h0102, 16'h0304, 4'd2, 1'b1, 1'b0);
        sb_q.push_back(mk(1'b1, 16'h0102, 16'h0304, 4'd2, 1'b1, 1'b0, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL ex_producer_r2: got %h, expected %h", got_e, exp_e);
        else passes++;
        drive_id(1'b1, 4'd2, 4'd11, 1'b1, 1'b1, 16'hBEEF, 16'hCAFE, 4'd12, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b0) $display("FAIL fwd_ex_no_stall: got %b, expected 0", stall);
        else passes++;
        sb_q.push_back(mk(1'b1, 16'hBEEF, 16'hCAFE, 4'd12, 1'b0, 1'b0, 2'd1, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL fwd_sel_a_ex: got %h, expected %h", got_e, exp_e);
        else passes++;
    endtask

    task automatic test_fwd_mem();
        mem_rd_addr = 4'd3;
        mem_reg_write = 1'b1;
        // rs also names r3 but is unused, so only sel_b forwards
        drive_id(1'b1, 4'd3, 4'd3, 1'b0, 1'b1, 16'h1234, 16'h5678, 4'd3, 1'b1, 1'b0);
        sb_q.push_back(mk(1'b1, 16'h1234, 16'h5678, 4'd3, 1'b1, 1'b0, 2'd0, 2'd2));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL fwd_sel_b_mem: got %h, expected %h", got_e, exp_e);
        else passes++;
        drive_id(1'b1, 4'd4, 4'd3, 1'b1, 1'b1, 16'h9ABC, 16'hDEF0, 4'd14, 1'b0, 1'b0);
        sb_q.push_back(mk(1'b1, 16'h9ABC, 16'hDEF0, 4'd14, 1'b0, 1'b0, 2'd0, 2'd1));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL fwd_ex_beats_mem: got %h, expected %h", got_e, exp_e);
        else passes++;
        // EX holds r14 without a write: must fall through to the MEM producer
        mem_rd_addr = 4'd14;
        drive_id(1'b1, 4'd14, 4'd1, 1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 4'd1, 1'b0, 1'b0);
        sb_q.push_back(mk(1'b1, 16'h0F0F, 16'hF0F0, 4'd1, 1'b0, 1'b0, 2'd2, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL fwd_ex_no_write: got %h, expected %h", got_e, exp_e);
        else passes++;
        mem_reg_write = 1'b0;
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 16'h4444, 16'h4040, 4'd4, 1'b1, 1'b1);
        sb_q.push_back(mk(1'b1, 16'h4444, 16'h4040, 4'd4, 1'b1, 1'b1, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL load_r4: got %h, expected %h", got_e, exp_e);
        else passes++;
        drive_id(1'b1, 4'd4, 4'd5, 1'b1, 1'b1, 16'h7777, 16'h8888, 4'd6, 1'b1, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b1) $display("FAIL load_use_stall: got %b, expected 1", stall);
        else passes++;
        sb_q.push_back(mk(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e || stall !== 1'b0) $display("FAIL load_use_bubble: got %h stall %b, expected %h stall 0", got_e, stall, exp_e);
        else passes++;
        mem_rd_addr = 4'd4;
        mem_reg_write = 1'b1;
        sb_q.push_back(mk(1'b1, 16'h7777, 16'h8888, 4'd6, 1'b1, 1'b0, 2'd2, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL load_use_retry: got %h, expected %h", got_e, exp_e);
        else passes++;
        mem_reg_write = 1'b0;
    endtask

    task automatic test_flush_hold();
        flush = 1'b1;
        hold = 1'b1;
        drive_id(1'b1, 4'd6, 4'd6, 1'b1, 1'b1, 16'h1357, 16'h2468, 4'd9, 1'b1, 1'b0);
        sb_q.push_back(mk(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL flush_over_hold: got %h, expected %h", got_e, exp_e);
        else passes++;
        flush = 1'b0;
        hold = 1'b0;
        drive_id(1'b1, 4'd7, 4'd8, 1'b1, 1'b1, 16'h1357, 16'h2468, 4'd9, 1'b1, 1'b0);
        sb_q.push_back(mk(1'b1, 16'h1357, 16'h2468, 4'd9, 1'b1, 1'b0, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL pre_hold_load: got %h, expected %h", got_e, exp_e);
        else passes++;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 4'd9, 4'd9, 1'b1, 1'b1, 16'(16'hF000 + i), 16'h0FFF, 4'(10 + i), 1'b1, 1'b1);
            sb_q.push_back(mk(1'b1, 16'h1357, 16'h2468, 4'd9, 1'b1, 1'b0, 2'd0, 2'd0));
            tick();
            got_e = observed();
            exp_e = sb_q.pop_front();
            checks++;
            if (got_e !== exp_e) $display("FAIL hold_cycle_%0d: got %h, expected %h", i, got_e, exp_e);
            else passes++;
        end
        hold = 1'b0;
        // Load to r7, then flush while ID's read of r7 still raises stall
        drive_id(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 16'h0007, 16'h0070, 4'd7, 1'b1, 1'b1);
        sb_q.push_back(mk(1'b1, 16'h0007, 16'h0070, 4'd7, 1'b1, 1'b1, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL load_r7: got %h, expected %h", got_e, exp_e);
        else passes++;
        flush = 1'b1;
        drive_id(1'b1, 4'd3, 4'd7, 1'b1, 1'b1, 16'h1111, 16'h2222, 4'd5, 1'b1, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b1) $display("FAIL flush_stall_visible: got %b, expected 1", stall);
        else passes++;
        sb_q.push_back(mk(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL flush_with_stall: got %h, expected %h", got_e, exp_e);
        else passes++;
        flush = 1'b0;
    endtask

    task automatic test_invalid_id();
        drive_id(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 16'h0909, 16'h9090, 4'd9, 1'b1, 1'b1);
        sb_q.push_back(mk(1'b1, 16'h0909, 16'h9090, 4'd9, 1'b1, 1'b1, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL load_r9: got %h, expected %h", got_e, exp_e);
        else passes++;
        drive_id(1'b0, 4'd9, 4'd9, 1'b1, 1'b1, 16'hABCD, 16'hDCBA, 4'd11, 1'b1, 1'b1);
        #1;
        checks++;
        if (stall !== 1'b0) $display("FAIL invalid_no_stall: got %b, expected 0", stall);
        else passes++;
        sb_q.push_back(mk(1'b0, 16'hABCD, 16'hDCBA, 4'd11, 1'b0, 1'b0, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL invalid_load: got %h, expected %h", got_e, exp_e);
        else passes++;
    endtask

    task automatic test_zero_reg();
        drive_id(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 16'h0A0A, 16'hA0A0, 4'd0, 1'b1, 1'b1);
        sb_q.push_back(mk(1'b1, 16'h0A0A, 16'hA0A0, 4'd0, 1'b1, 1'b1, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL load_r0: got %h, expected %h", got_e, exp_e);
        else passes++;
        mem_rd_addr = 4'd0;
        mem_reg_write = 1'b1;
        drive_id(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 16'h5A5A, 16'hA5A5, 4'd3, 1'b1, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b0) $display("FAIL zero_reg_no_stall: got %b, expected 0", stall);
        else passes++;
        sb_q.push_back(mk(1'b1, 16'h5A5A, 16'hA5A5, 4'd3, 1'b1, 1'b0, 2'd0, 2'd0));
        tick();
        got_e = observed();
        exp_e = sb_q.pop_front();
        checks++;
        if (got_e !== exp_e) $display("FAIL zero_reg_no_fwd: got %h, expected %h", got_e, exp_e);
        else passes++;
        mem_reg_write = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwd_ex();
        test_fwd_mem();
        test_load_use();
        test_flush_hold();
        test_invalid_id();
        test_zero_reg();
        checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
